// File: rtl/sram_spi_ctrl_pkg.sv
// rtl/sram_spi_ctrl_pkg.sv - shared opcodes, frame geometry and FSM encoding for the serial SRAM controller
package sram_spi_ctrl_pkg;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam int         FRAME_BITS = 40;
  localparam int         ADDR_W     = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_END,
    ST_GAP
  } state_e;

  // Opcode, 24-bit address with the unused top bits zero, then the data byte.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic              we,
                                                        input logic [ADDR_W-1:0] addr,
                                                        input logic [7:0]        wdata);
    return {(we ? CMD_WRITE : CMD_READ), 7'b0, addr, (we ? wdata : 8'h00)};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// rtl/spi_sck_gen.sv - half-period divider producing SCK plus tick/rise/fall strobes
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic toggle_en,
  output logic sck,
  output logic tick,
  output logic rise,
  output logic fall
);

  logic [7:0] cnt_q, cnt_d;
  logic       sck_q, sck_d;

  assign tick = en && (cnt_q == 8'(CLK_DIV - 1));
  assign rise = tick && toggle_en && !sck_q;
  assign fall = tick && toggle_en && sck_q;
  assign sck  = sck_q;

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (tick) begin
      cnt_d = '0;
      if (toggle_en) sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/sram_spi_ctrl.sv
// rtl/sram_spi_ctrl.sv - single-byte read/write controller for an M23A1024 serial SRAM, SPI mode 0
module sram_spi_ctrl
  import sram_spi_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [7:0]        WDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic [7:0]        RDATA,
  output logic              SCK,
  output logic              CS_N,
  output logic              SI_SIO0,
  input  logic              SO_SIO1,
  output logic              HOLD_N_SIO3
);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [7:0]            rx_q, rx_d;
  logic [7:0]            rdata_q, rdata_d;
  logic [5:0]            bit_cnt_q, bit_cnt_d;
  logic                  done_q, done_d;

  logic gen_en, gen_toggle, sck, tick, rise, fall, cs_active;

  // The divider also times SETUP/END/GAP; SCK only toggles while the frame is on the wire.
  assign gen_en     = (state_q != ST_IDLE);
  assign gen_toggle = (state_q == ST_SETUP) || (state_q == ST_SHIFT);
  assign cs_active  = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_END);

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk       (CLK),
    .rst       (RESET),
    .en        (gen_en),
    .toggle_en (gen_toggle),
    .sck       (sck),
    .tick      (tick),
    .rise      (rise),
    .fall      (fall)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;

    if (rise) rx_d = {rx_q[6:0], SO_SIO1};

    unique case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          we_d      = WE;
          shift_d   = build_frame(WE, ADDR, WDATA);
          bit_cnt_d = '0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (rise) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (fall) begin
          shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'(FRAME_BITS - 1)) state_d = ST_END;
        end
      end
      ST_END: begin
        if (tick) begin
          done_d  = 1'b1;
          if (!we_q) rdata_d = rx_q;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      shift_q   <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
    end
  end

  assign BUSY        = (state_q != ST_IDLE);
  assign DONE        = done_q;
  assign RDATA       = rdata_q;
  assign SCK         = sck;
  assign CS_N        = !cs_active;
  assign SI_SIO0     = cs_active ? shift_q[FRAME_BITS-1] : 1'b0;
  assign HOLD_N_SIO3 = 1'b1;

endmodule

// File: tb/tb_sram_spi_ctrl.sv
// tb/tb_sram_spi_ctrl.sv - randomized bench for sram_spi_ctrl with an M23A1024 byte-mode model
module tb_sram_spi_ctrl;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [16:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        busy, done, sck, cs_n, si, hold_n;
  logic [7:0]  rdata;
  logic        so = 1'b0;

  logic        req1 = 1'b0, we1 = 1'b0;
  logic [16:0] addr1 = '0;
  logic [7:0]  wdata1 = '0;
  logic        busy1, done1, sck1, cs_n1, si1, hold_n1;
  logic [7:0]  rdata1;
  logic        so1 = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [7:0] ref_mem [int];
  logic [7:0] ref_rdata = 8'h00;

  always #5 clk = ~clk;

  sram_spi_ctrl #(.CLK_DIV(D)) dut (
    .CLK(clk), .RESET(reset), .REQ(req), .WE(we), .ADDR(addr), .WDATA(wdata),
    .BUSY(busy), .DONE(done), .RDATA(rdata), .SCK(sck), .CS_N(cs_n),
    .SI_SIO0(si), .SO_SIO1(so), .HOLD_N_SIO3(hold_n)
  );

  sram_spi_ctrl #(.CLK_DIV(1)) dut1 (
    .CLK(clk), .RESET(reset), .REQ(req1), .WE(we1), .ADDR(addr1), .WDATA(wdata1),
    .BUSY(busy1), .DONE(done1), .RDATA(rdata1), .SCK(sck1), .CS_N(cs_n1),
    .SI_SIO0(si1), .SO_SIO1(so1), .HOLD_N_SIO3(hold_n1)
  );

  // M23A1024 byte-mode model: samples SI on SCK rise, drives SO on SCK fall
  logic [7:0]  mem [0:131071];
  logic [39:0] m_sr = '0;
  int          m_n = 0;
  logic [7:0]  m_op = '0;
  logic [16:0] m_addr = '0;

  initial for (int i = 0; i < 131072; i++) mem[i] = 8'h00;

  always @(posedge sck or posedge cs_n) begin
    if (cs_n) begin
      m_n = 0;
    end else begin
      m_sr = {m_sr[38:0], si};
      m_n++;
      if (m_n == 8)  m_op = m_sr[7:0];
      if (m_n == 32) m_addr = m_sr[16:0];
      if (m_n == 40 && m_op == 8'h02) mem[m_addr] = m_sr[7:0];
    end
  end

  always @(negedge sck)
    if (!cs_n && m_op == 8'h03 && m_n >= 32 && m_n < 40) so = mem[m_addr][39 - m_n];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_read(input logic [16:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic run_txn(input logic t_we, input logic [16:0] t_addr, input logic [7:0] t_wdata,
                         input int inject_at, input int reset_at);
    logic [39:0] stream, exp_frame;
    logic [16:0] inj_addr;
    int nrise, first_rise, last_rise, cs_low_c, done_c, done_n, busy_low_c;
    logic prev_sck;
    exp_frame  = {(t_we ? 8'h02 : 8'h03), 7'b0, t_addr, (t_we ? t_wdata : 8'h00)};
    inj_addr   = t_addr ^ 17'h00155;
    stream     = '0;
    nrise      = 0;
    first_rise = -1;
    last_rise  = -1;
    cs_low_c   = -1;
    done_c     = -1;
    done_n     = 0;
    busy_low_c = -1;
    prev_sck   = 1'b0;
    wait_idle();
    @(negedge clk);
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
    @(posedge clk);
    for (int c = 1; c <= 1 + 82 * D + 2; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req = 1'b0; we = 1'($urandom); addr = 17'($urandom); wdata = 8'($urandom);
      end
      if (!cs_n && cs_low_c < 0) cs_low_c = c;
      if (sck && !prev_sck) begin
        stream = {stream[38:0], si};
        if (nrise == 0) first_rise = c;
        last_rise = c;
        nrise++;
      end
      prev_sck = sck;
      if (done) begin
        done_n++;
        done_c = c;
      end
      if (!busy && busy_low_c < 0) busy_low_c = c;
      if (c == inject_at) begin
        req = 1'b1; we = 1'b1; addr = inj_addr; wdata = ~t_wdata;
      end
      if (c == inject_at + 1) req = 1'b0;
      if (c == reset_at) reset = 1'b1;
      if (c == reset_at + 1) begin
        check("abort_cs_n", cs_n, 1);
        check("abort_sck", sck, 0);
        check("abort_busy", busy, 0);
        check("abort_no_done", done_n, 0);
        check("abort_rdata", rdata, 8'h00);
        reset = 1'b0;
        ref_rdata = 8'h00;
        return;
      end
    end
    check("cs_low_cycle", cs_low_c, 1);
    check("sck_rises", nrise, 40);
    check("first_rise", first_rise, 1 + D);
    check("last_rise", last_rise, 1 + D + 78 * D);
    check("si_frame", stream, exp_frame);
    check("done_count", done_n, 1);
    check("done_cycle", done_c, 1 + 81 * D);
    check("busy_low_cycle", busy_low_c, 1 + 82 * D);
    if (t_we) begin
      ref_mem[int'(t_addr)] = t_wdata;
      check("write_mem", mem[t_addr], t_wdata);
      check("write_keeps_rdata", rdata, ref_rdata);
    end else begin
      ref_rdata = ref_read(t_addr);
      check("read_rdata", rdata, ref_rdata);
    end
    if (inject_at > 0) check("ignored_req_mem", mem[inj_addr], ref_read(inj_addr));
  endtask

  task automatic run_b2b();
    int f1, r1, f2, rise1, rise2;
    logic pc, ps;
    f1 = -1; r1 = -1; f2 = -1; rise1 = -1; rise2 = -1;
    pc = 1'b1; ps = 1'b0;
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 17'($urandom); wdata1 = 8'($urandom);
    @(posedge clk);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (!cs_n1 && pc) begin
        if (f1 < 0) f1 = c;
        else if (f2 < 0) f2 = c;
      end
      if (cs_n1 && !pc && r1 < 0) r1 = c;
      if (sck1 && !ps) begin
        if (rise1 < 0) rise1 = c;
        else if (rise2 < 0) rise2 = c;
      end
      pc = cs_n1;
      ps = sck1;
      if (f2 >= 0) break;
    end
    req1 = 1'b0;
    check("d1_cs_low", f1, 1);
    check("d1_first_rise", rise1, 2);
    check("d1_sck_period", rise2 - rise1, 2);
    check("d1_cs_high", r1, 82);
    check("d1_b2b_cs_low", f2, 84);
    for (int n = 0; n < 200 && busy1; n++) @(negedge clk);
    check("d1_idle", busy1, 0);
  endtask

  initial begin
    logic [16:0] a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_sck", sck, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_si", si, 0);
    check("rst_hold_n", hold_n, 1);
    reset = 1'b0;
    @(negedge clk);

    run_txn(1'b1, 17'h00010, 8'hA5, -1, -1);
    run_txn(1'b0, 17'h00010, 8'h00, -1, -1);
    run_txn(1'b1, 17'h1FFFF, 8'h3C, -1, -1);
    run_txn(1'b0, 17'h1FFFF, 8'h00, -1, -1);
    run_txn(1'b1, 17'h00200, 8'h5A, 50, -1);
    run_txn(1'b0, 17'h00010, 8'h00, -1, 60);
    run_txn(1'b0, 17'h00200, 8'h00, -1, -1);

    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 17'h00010;
        1:       a = 17'h1FFFF;
        2:       a = 17'h00200;
        default: a = 17'($urandom);
      endcase
      run_txn(1'($urandom), a, 8'($urandom), -1, -1);
    end

    run_b2b();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/sram_spi_ctrl.md
SRAM_SPI_CTRL -- requirements
Module: sram_spi_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 2, SCK half-period in CLK cycles; legal range 1..255.
REQ-002 CLK  input  1  system clock; all logic on rising edge.
REQ-003 RESET  input  1  reset is synchronous and active-high.
REQ-004 REQ  input  1  host request; sampled only while BUSY=0.
REQ-005 WE  input  1  1=byte write, 0=byte read; captured with REQ.
REQ-006 ADDR  input  17  byte address (128 KB device); captured with REQ.
REQ-007 WDATA  input  8  write byte; captured with REQ.
REQ-008 BUSY  output  1  transaction in progress.
REQ-009 DONE  output  1  one-CLK pulse at transaction end.
REQ-010 RDATA  output  8  last byte read; held until next read completes.
REQ-011 SCK  output  1  SPI clock to M23A1024.
REQ-012 CS_N  output  1  chip select, active low.
REQ-013 SI_SIO0  output  1  serial data to memory (MOSI).
REQ-014 SO_SIO1  input  1  serial data from memory (MISO).
REQ-015 HOLD_N_SIO3  output  1  tied 1; SIO2 is not driven.

Function
REQ-016 SPI mode 0 throughout: SCK idles low; SI_SIO0 changes only when SCK is low; SO_SIO1 is sampled on the CLK cycle that drives SCK high.
REQ-017 Frame is 40 bits, MSB first: opcode (READ 8'h03 / WRITE 8'h02), 24-bit address {7'b0, ADDR}, 8 data bits (WDATA on write, don't-care 0 on read).
REQ-018 FSM states: IDLE, SETUP, SHIFT, END, GAP.
REQ-019 IDLE: BUSY=0, CS_N=1, SCK=0; REQ=1 captures WE/ADDR/WDATA and moves to SETUP next cycle.
REQ-020 SETUP (D=CLK_DIV cycles): BUSY=1, CS_N=0, SI_SIO0=frame bit 39; then SHIFT.
REQ-021 SHIFT: 40 SCK periods of 2*D cycles (D high, D low); next bit presented on each falling edge; after 40th falling edge go to END.
REQ-022 END (D cycles, SCK=0, CS_N=0), then CS_N=1, DONE=1 for one cycle, RDATA updated if read; enter GAP.
REQ-023 GAP (D cycles, CS_N=1): BUSY stays 1; then IDLE.
REQ-024 Timing from REQ-accept edge as cycle 0: CS_N low cycle 1; k-th SCK rise (k=0..39) at 1+D+2Dk; CS_N high and DONE at 1+81D; BUSY low at 1+82D (D=2: 163/165).
REQ-025 RDATA bits come from the last 8 SCK rises of a read; a write leaves RDATA unchanged.
REQ-026 REQ while BUSY=1 is ignored, not queued; captured operands are immune to input changes mid-transaction.
REQ-027 REQ held high continuously starts a new transaction on the cycle BUSY falls; no other back-to-back overlap.
REQ-028 ADDR=17'h1FFFF is legal; no address wrap logic in the block.

Reset
REQ-029 On RESET: state=IDLE, BUSY=0, DONE=0, RDATA=8'h00, SCK=0, CS_N=1, SI_SIO0=0, all counters 0.
REQ-030 RESET mid-transaction aborts on the next edge: CS_N=1, SCK=0, no DONE pulse, RDATA unchanged from reset value.

Structure
REQ-031 Shared package holds CMD_READ, CMD_WRITE, FRAME_BITS=40, ADDR_W=17, and FSM state encoding.
REQ-032 One sub-module, spi_sck_gen: divider producing SCK level plus rise/fall strobes, enabled by the FSM.
REQ-033 Shift register 40 bits out, 8 bits in; bit counter 6 bits; divider counter 8 bits.

Verification
REQ-034 Bench uses the M23A1024 behavioral model with SIO pins connected as per REQ-013..015.
REQ-035 Write ADDR=17'h00010 WDATA=8'hA5, D=2 -> SI_SIO0 stream 02_000010_A5, DONE at cycle 163, BUSY low at 165.
REQ-036 Read ADDR=17'h00010 after REQ-035 -> opcode 03 on SI_SIO0, RDATA=8'hA5 at DONE.
REQ-037 Write 8'h3C to 17'h1FFFF then read 17'h1FFFF -> RDATA=8'h3C; address bits 23..17 sent as 0.
REQ-038 REQ pulsed at cycle 50 of a transaction with other operands -> ignored; only one DONE; memory unchanged at new address.
REQ-039 RESET asserted at cycle 60 of a read -> next cycle CS_N=1, SCK=0, BUSY=0, no DONE; following read completes correctly.
REQ-040 CLK_DIV=1, REQ held high for two writes -> SCK period 2 cycles, second CS_N low exactly 2 cycles after first CS_N high.
